cdb_arbiter: RTL and testbench

//  Shares the two common data buses (CDB1, CDB2) among the functional units that feed them.

---
 rtl/cdb_arbiter.sv | 118 +++++++++++
 tb/tb_cdb_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants up to two pending FU results per cycle onto the registered CDB1/CDB2 buses.
// Build option CDB_ARB_RR_EN: defined selects round-robin arbitration; undefined selects fixed priority (FU 0 highest, rr_ptr held at 0).
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W = 3,
    parameter logic [7:0] TAG_NULL = 8'hFF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [8*NUM_REQ-1:0]    req_tag,
    input  logic [64*NUM_REQ-1:0]   req_value,
    output logic [NUM_REQ-1:0]      grant,
    output logic [7:0]              cdb1_tag_out,
    output logic [63:0]             cdb1_value_out,
    output logic [7:0]              cdb2_tag_out,
    output logic [63:0]             cdb2_value_out,
    output logic [PTR_W-1:0]        rr_ptr_out
);
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] nxt_ptr;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] g1;
    logic [NUM_REQ-1:0] g2;
    logic has1;
    logic has2;
    logic go;
    logic [7:0] tag1;
    logic [7:0] tag2;
    logic [63:0] val1;
    logic [63:0] val2;

    assign go = !reset && !flush;
    assign grant = go ? (g1 | g2) : '0;
    assign rr_ptr_out = rr_ptr;

    // a valid request carrying the null tag is never eligible
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = req_valid[i] && (req_tag[8*i +: 8] != TAG_NULL);
    end

    // scan from rr_ptr with wrap; first eligible FU takes CDB1, second takes CDB2
    always_comb begin
        int idx;
        logic [NUM_REQ-1:0] e_sh;
        logic [8*NUM_REQ-1:0] t_sh;
        logic [64*NUM_REQ-1:0] v_sh;
        has1 = 1'b0;
        has2 = 1'b0;
        g1 = '0;
        g2 = '0;
        tag1 = TAG_NULL;
        tag2 = TAG_NULL;
        val1 = '0;
        val2 = '0;
        idx = 0;
        e_sh = '0;
        t_sh = '0;
        v_sh = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            e_sh = elig >> idx;
            t_sh = req_tag >> (idx * 8);
            v_sh = req_value >> (idx * 64);
            if (e_sh[0] && !has2) begin
                if (!has1) begin
                    has1 = 1'b1;
                    g1 = NUM_REQ'(1) << idx;
                    tag1 = t_sh[7:0];
                    val1 = v_sh[63:0];
                end else begin
                    has2 = 1'b1;
                    g2 = NUM_REQ'(1) << idx;
                    tag2 = t_sh[7:0];
                    val2 = v_sh[63:0];
                end
            end
        end
    end

`ifdef CDB_ARB_RR_EN
    // next pointer sits just past the last FU granted in scan order
    always_comb begin
        logic [NUM_REQ-1:0] last_oh;
        last_oh = has2 ? g2 : g1;
        nxt_ptr = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (last_oh[i]) nxt_ptr = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
    end
`else
    assign nxt_ptr = '0;
`endif

    // pointer moves only on a real grant; flush and idle cycles hold it
    always_ff @(posedge clock) begin
        if (reset) rr_ptr <= '0;
        else if (go && has1) rr_ptr <= nxt_ptr;
    end

    // register granted results; an ungranted bus goes null for one cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            cdb1_tag_out <= TAG_NULL;
            cdb1_value_out <= '0;
            cdb2_tag_out <= TAG_NULL;
            cdb2_value_out <= '0;
        end else begin
            cdb1_tag_out <= (go && has1) ? tag1 : TAG_NULL;
            cdb1_value_out <= (go && has1) ? val1 : '0;
            cdb2_tag_out <= (go && has2) ? tag2 : TAG_NULL;
            cdb2_value_out <= (go && has2) ? val2 : '0;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for cdb_arbiter covering both arbitration builds.
module tb_cdb_arbiter;
`ifdef CDB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic [3:0] req_valid = '0;
    logic [31:0] req_tag = '0;
    logic [255:0] req_value = '0;
    logic [3:0] grant;
    logic [7:0] cdb1_tag_out;
    logic [63:0] cdb1_value_out;
    logic [7:0] cdb2_tag_out;
    logic [63:0] cdb2_value_out;
    logic [2:0] rr_ptr_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] g;
        logic [7:0] t1;
        logic [7:0] t2;
        logic [63:0] v1;
        logic [63:0] v2;
        logic [2:0] p;
    } exp_t;

    exp_t q[$];

    cdb_arbiter dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .req_valid(req_valid),
        .req_tag(req_tag),
        .req_value(req_value),
        .grant(grant),
        .cdb1_tag_out(cdb1_tag_out),
        .cdb1_value_out(cdb1_value_out),
        .cdb2_tag_out(cdb2_tag_out),
        .cdb2_value_out(cdb2_value_out),
        .rr_ptr_out(rr_ptr_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // drive one cycle of inputs and queue what the DUT must show for it
    task automatic cyc(input logic rs, input logic fl, input logic [3:0] v, input logic [31:0] tags,
                       input logic [3:0] eg, input int e1, input int e2, input logic [2:0] ep);
        exp_t e;
        @(posedge clock);
        #2;
        reset = rs;
        flush = fl;
        req_valid = v;
        req_tag = tags;
        for (int i = 0; i < 4; i++)
            req_value[i*64 +: 64] = {8'(i), 48'h0123_4567_89AB, tags[i*8 +: 8]};
        if (tags[23:16] == 8'h05) req_value[191:128] = 64'hDEADBEEFBAADBEEF;
        e.g = eg;
        e.p = ep;
        e.t1 = 8'hFF;
        e.v1 = '0;
        e.t2 = 8'hFF;
        e.v2 = '0;
        if (e1 >= 0) begin
            e.t1 = req_tag[e1*8 +: 8];
            e.v1 = req_value[e1*64 +: 64];
        end
        if (e2 >= 0) begin
            e.t2 = req_tag[e2*8 +: 8];
            e.v2 = req_value[e2*64 +: 64];
        end
        q.push_back(e);
    endtask

    // monitor: grant belongs to this cycle's entry, cdb/pointer to the previous one
    initial begin
        exp_t e;
        exp_t prev;
        bit hp;
        hp = 1'b0;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("grant", 64'(grant), 64'(e.g));
                if (hp) begin
                    chk("cdb1_tag", 64'(cdb1_tag_out), 64'(prev.t1));
                    chk("cdb1_value", cdb1_value_out, prev.v1);
                    chk("cdb2_tag", 64'(cdb2_tag_out), 64'(prev.t2));
                    chk("cdb2_value", cdb2_value_out, prev.v2);
                    chk("rr_ptr", 64'(rr_ptr_out), 64'(prev.p));
                end
                prev = e;
                hp = 1'b1;
            end
        end
    end

    initial begin
        cyc(1, 0, 4'b0000, 32'h0000_0000, 4'b0000, -1, -1, 3'd0);
        cyc(0, 0, 4'b0100, 32'h0005_0000, 4'b0100, 2, -1, RR ? 3'd3 : 3'd0);
        cyc(0, 0, 4'b1001, 32'h2300_0020, 4'b1001, RR ? 3 : 0, RR ? 0 : 3, RR ? 3'd1 : 3'd0);
        cyc(0, 0, 4'b1000, 32'h3300_0000, 4'b1000, 3, -1, 3'd0);
        cyc(0, 0, 4'b1111, 32'h1312_1110, 4'b0011, 0, 1, RR ? 3'd2 : 3'd0);
        cyc(0, 0, 4'b1111, 32'h1312_1110, RR ? 4'b1100 : 4'b0011, RR ? 2 : 0, RR ? 3 : 1, 3'd0);
        cyc(0, 0, 4'b0010, 32'h0000_FF00, 4'b0000, -1, -1, 3'd0);
        cyc(0, 0, 4'b0110, 32'h0042_FF00, 4'b0100, 2, -1, RR ? 3'd3 : 3'd0);
        cyc(0, 1, 4'b0111, 32'h0052_5150, 4'b0000, -1, -1, RR ? 3'd3 : 3'd0);
        cyc(1, 1, 4'b1111, 32'h6362_6160, 4'b0000, -1, -1, 3'd0);
        cyc(0, 0, 4'b0110, 32'h0072_7100, 4'b0110, 1, 2, RR ? 3'd3 : 3'd0);
        cyc(0, 0, 4'b0111, 32'h0082_8180, 4'b0011, 0, 1, RR ? 3'd2 : 3'd0);
        cyc(0, 0, 4'b0101, 32'h0090_0090, 4'b0101, RR ? 2 : 0, RR ? 0 : 2, RR ? 3'd1 : 3'd0);
        cyc(0, 0, 4'b0000, 32'h0000_0000, 4'b0000, -1, -1, RR ? 3'd1 : 3'd0);
        cyc(0, 0, 4'b0000, 32'h0000_0000, 4'b0000, -1, -1, RR ? 3'd1 : 3'd0);
        repeat (2) @(posedge clock);
        #6;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
